// File: rtl/drone_pkg.sv
// Shared motor-path types and constants: motor indices, set-point type, PWM arming states.
package drone_pkg;

  localparam int NUM_MOTORS = 4;

  localparam int MOT_L  = 0;
  localparam int MOT_R  = 1;
  localparam int MOT_F  = 2;
  localparam int MOT_RV = 3;

  typedef logic [15:0] rpm_t;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMING   = 2'd1,
    ARMED    = 2'd2
  } pwm_state_t;

  function automatic rpm_t clamp_pulse(input rpm_t v, input rpm_t lo, input rpm_t hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One ESC channel: clamp, duty register (optionally slew-limited under MOTOR_PWM_SLEW_EN), compare.
// Duty takes effect at the next cnt = 0; pwm is registered (1 cycle); no backpressure.
module pwm_channel
  import drone_pkg::*;
#(
  parameter int MIN_PULSE = 1000,
  parameter int MAX_PULSE = 2000
`ifdef MOTOR_PWM_SLEW_EN
  ,
  parameter int SLEW_STEP = 20
`endif
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] cnt,
  input  logic        boundary,
  input  logic [1:0]  state,
  input  logic [1:0]  state_nxt,
  input  logic [15:0] mot_set,
  output logic        pwm
);

  localparam rpm_t MIN_P = rpm_t'(MIN_PULSE);
  localparam rpm_t MAX_P = rpm_t'(MAX_PULSE);

  rpm_t tgt;
  rpm_t duty;
  rpm_t duty_step;

  assign tgt = clamp_pulse(mot_set, MIN_P, MAX_P);

`ifdef MOTOR_PWM_SLEW_EN
  localparam rpm_t              STEP   = rpm_t'(SLEW_STEP);
  localparam logic signed [16:0] STEP_S = 17'(SLEW_STEP);

  logic signed [16:0] diff;

  always_comb begin
    duty_step = tgt;
    diff      = $signed({1'b0, tgt}) - $signed({1'b0, duty});
    if (diff > STEP_S)
      duty_step = duty + STEP;
    else if (diff < -STEP_S)
      duty_step = duty - STEP;
  end
`else
  always_comb begin
    duty_step = tgt;
  end
`endif

  // Tracking keys off the next state so the boundary that enters ARMED already takes the first step,
  // and a disarm on a boundary discards the update.
  always_ff @(posedge clk) begin
    if (resetn) begin
      duty <= MIN_P;
      pwm  <= 1'b0;
    end else begin
      if (state_nxt != ARMED)
        duty <= MIN_P;
      else if (boundary)
        duty <= duty_step;
      pwm <= (state != DISARMED) && (cnt < duty);
    end
  end

endmodule

// File: rtl/motor_pwm_gen.sv
// Four-channel ESC PWM generator with arming sequence, clamp and per-period slew (MOTOR_PWM_SLEW_EN).
// Set-points latched at cnt = PERIOD_CYCLES-1, visible from next period; disarm is immediate; no backpressure.
module motor_pwm_gen
  import drone_pkg::*;
#(
  parameter int PERIOD_CYCLES = 20000,
  parameter int MIN_PULSE     = 1000,
  parameter int MAX_PULSE     = 2000,
  parameter int SLEW_STEP     = 20,
  parameter int ARM_PERIODS   = 50
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         arm,
  input  logic [NUM_MOTORS-1:0][15:0]  mot_set,
  output logic [NUM_MOTORS-1:0]        pwm_out,
  output logic                         armed,
  output logic                         period_start
);

  if (PERIOD_CYCLES < 2 || PERIOD_CYCLES > 65535 || MIN_PULSE > MAX_PULSE ||
      MAX_PULSE >= PERIOD_CYCLES || SLEW_STEP < 1 || ARM_PERIODS < 1 || ARM_PERIODS > 65536) begin : g_bad_cfg
    $error("motor_pwm_gen: illegal parameter set");
  end

  localparam logic [15:0] CNT_MAX  = 16'(PERIOD_CYCLES - 1);
  localparam logic [15:0] ARM_LAST = 16'(ARM_PERIODS - 1);

  logic [15:0] cnt;
  logic        boundary;
  pwm_state_t  state, state_nxt;
  logic [15:0] arm_cnt, arm_cnt_nxt;

  assign boundary = (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (resetn) begin
      cnt          <= '0;
      period_start <= 1'b0;
      state        <= DISARMED;
      arm_cnt      <= '0;
    end else begin
      cnt          <= boundary ? '0 : cnt + 16'd1;
      period_start <= boundary;
      state        <= state_nxt;
      arm_cnt      <= arm_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    arm_cnt_nxt = arm_cnt;
    case (state)
      DISARMED: begin
        arm_cnt_nxt = '0;
        if (arm && boundary)
          state_nxt = ARMING;
      end
      ARMING: begin
        if (!arm) begin
          state_nxt   = DISARMED;
          arm_cnt_nxt = '0;
        end else if (boundary) begin
          arm_cnt_nxt = arm_cnt + 16'd1;
          if (arm_cnt == ARM_LAST)
            state_nxt = ARMED;
        end
      end
      ARMED: begin
        if (!arm) begin
          state_nxt   = DISARMED;
          arm_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt   = DISARMED;
        arm_cnt_nxt = '0;
      end
    endcase
  end

  assign armed = (state == ARMED);

  for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_ch
    pwm_channel #(
      .MIN_PULSE (MIN_PULSE),
      .MAX_PULSE (MAX_PULSE)
`ifdef MOTOR_PWM_SLEW_EN
      ,
      .SLEW_STEP (SLEW_STEP)
`endif
    ) u_ch (
      .clk       (clk),
      .resetn    (resetn),
      .cnt       (cnt),
      .boundary  (boundary),
      .state     (state),
      .state_nxt (state_nxt),
      .mot_set   (mot_set[i]),
      .pwm       (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_motor_pwm_gen.sv
// Scoreboard bench for motor_pwm_gen: period-level reference model feeds an expected-output queue,
// a negedge monitor compares; directed pulse-width checks cover arming, clamp, sampling and disarm.
module tb_motor_pwm_gen;

  localparam int P    = 100;
  localparam int MINP = 10;
  localparam int MAXP = 80;
  localparam int SLEW = 5;
  localparam int ARMP = 2;

  logic             clk = 1'b0;
  logic             resetn;
  logic             arm;
  logic [3:0][15:0] mot_set;
  logic [3:0]       pwm_out;
  logic             armed;
  logic             period_start;

  always #5 clk = ~clk;

  motor_pwm_gen #(
    .PERIOD_CYCLES (P),
    .MIN_PULSE     (MINP),
    .MAX_PULSE     (MAXP),
    .SLEW_STEP     (SLEW),
    .ARM_PERIODS   (ARMP)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .arm          (arm),
    .mot_set      (mot_set),
    .pwm_out      (pwm_out),
    .armed        (armed),
    .period_start (period_start)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0] pwm;
    logic       armed;
    logic       ps;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: position in period, mode (0 off, 1 arming, 2 armed), periods spent arming, duty per motor.
  int   m_cnt  = 0;
  int   m_mode = 0;
  int   m_per  = 0;
  int   m_duty [4] = '{MINP, MINP, MINP, MINP};
  exp_t m_e;

  function automatic int clampv(input int v);
    return (v < MINP) ? MINP : ((v > MAXP) ? MAXP : v);
  endfunction

  function automatic int next_duty(input int d, input int t);
`ifdef MOTOR_PWM_SLEW_EN
    if (t > d + SLEW) return d + SLEW;
    if (t < d - SLEW) return d - SLEW;
    return t;
`else
    return t + 0 * d;
`endif
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      m_e = '0;
      if (resetn) begin
        m_cnt  = 0;
        m_mode = 0;
        m_per  = 0;
        for (int i = 0; i < 4; i++) m_duty[i] = MINP;
      end else begin
        for (int i = 0; i < 4; i++)
          m_e.pwm[i] = (m_mode != 0) && (m_cnt < m_duty[i]);
        if (m_mode != 0 && !arm) begin
          m_mode = 0;
          m_per  = 0;
          for (int i = 0; i < 4; i++) m_duty[i] = MINP;
        end else if (m_cnt == P - 1) begin
          if (m_mode == 0) begin
            if (arm) begin
              m_mode = 1;
              m_per  = 0;
            end
          end else begin
            if (m_mode == 1) begin
              m_per++;
              if (m_per == ARMP) m_mode = 2;
            end
            if (m_mode == 2)
              for (int i = 0; i < 4; i++)
                m_duty[i] = next_duty(m_duty[i], clampv(int'(mot_set[i])));
          end
        end
        m_cnt     = (m_cnt + 1) % P;
        m_e.armed = (m_mode == 2);
        m_e.ps    = (m_cnt == 0);
      end
      exp_q.push_back(m_e);
    end
  end

  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_empty at %0t: DUT produced outputs with no expectation queued", $time);
      end else begin
        mon_e = exp_q.pop_front();
        if ({pwm_out, armed, period_start} !== mon_e) begin
          n_err++;
          $display("FAIL cycle_outputs at %0t: got pwm=%b armed=%b ps=%b, expected pwm=%b armed=%b ps=%b",
                   $time, pwm_out, armed, period_start, mon_e.pwm, mon_e.armed, mon_e.ps);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Leaves the caller in the cycle where the model counter equals v.
  task automatic wait_cnt(input int v);
    bit hit = 1'b0;
    for (int k = 0; k < 2 * P + 2 && !hit; k++) begin
      @(posedge clk);
      #1;
      if (m_cnt == v) hit = 1'b1;
    end
    if (!hit) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_cnt_timeout: counter %0d never reached", v);
    end
  endtask

  task automatic meas_now(input int ch, output int w);
    w = 0;
    for (int k = 0; k < P; k++) begin
      @(negedge clk);
      w += int'(pwm_out[ch]);
    end
  endtask

  task automatic meas(input int ch, output int w);
    wait_cnt(0);
    meas_now(ch, w);
  endtask

  int w;
  int n_ps, n_hi, n_arm;
`ifdef MOTOR_PWM_SLEW_EN
  int arm_seq [9] = '{10, 10, 15, 20, 25, 30, 35, 40, 40};
  localparam int REARM3   = 15;
  localparam int EDGE_W   = 35;
`else
  int arm_seq [9] = '{10, 10, 40, 40, 40, 40, 40, 40, 40};
  localparam int REARM3   = 40;
  localparam int EDGE_W   = 70;
`endif

  initial begin
    resetn  = 1'b1;
    arm     = 1'b0;
    mot_set = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pwm", int'(pwm_out), 0);
    chk("reset_armed", int'(armed), 0);
    chk("reset_ps", int'(period_start), 0);
    resetn = 1'b0;

    n_ps = 0; n_hi = 0; n_arm = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      n_ps  += int'(period_start);
      n_hi  += (pwm_out != 4'b0000) ? 1 : 0;
      n_arm += int'(armed);
    end
    chk("idle_period_start_count", n_ps, 2);
    chk("idle_pwm_high_cycles", n_hi, 0);
    chk("idle_armed_cycles", n_arm, 0);

    mot_set[0] = 16'd40;
    mot_set[1] = 16'd5;
    mot_set[2] = 16'hFFFF;
    mot_set[3] = 16'd30;
    wait_cnt(50);
    arm = 1'b1;
    for (int p = 0; p < 9; p++) begin
      meas(0, w);
      chk($sformatf("arm_seq_p%0d", p), w, arm_seq[p]);
    end
    chk("armed_after_arming", int'(armed), 1);

    for (int p = 0; p < 9; p++) meas(2, w);
    meas(2, w);
    chk("clamp_high_ch2", w, MAXP);
    meas(1, w);
    chk("clamp_low_ch1", w, MINP);

    wait_cnt(30);
    mot_set[3] = 16'd70;
    wait_cnt(60);
    mot_set[3] = 16'd30;
    meas(3, w);
    chk("midperiod_toggle_ignored", w, 30);

    wait_cnt(P - 1);
    mot_set[3] = 16'd70;
    wait_cnt(0);
    mot_set[3] = 16'd30;
    meas_now(3, w);
    chk("boundary_sample_used", w, EDGE_W);

    wait_cnt(20);
    arm = 1'b0;
    wait_cnt(22);
    chk("disarm_pwm_cnt22", int'(pwm_out), 0);
    chk("disarm_armed_cnt22", int'(armed), 0);

    wait_cnt(50);
    arm = 1'b1;
    for (int p = 0; p < 3; p++) begin
      meas(0, w);
      chk($sformatf("rearm_p%0d", p), w, (p < 2) ? MINP : REARM3);
    end

    wait_cnt(P - 1);
    arm = 1'b0;
    wait_cnt(0);
    chk("boundary_disarm_armed", int'(armed), 0);
    meas_now(0, w);
    chk("boundary_disarm_pulse", w, 0);
    arm = 1'b1;

    for (int k = 0; k < 4000; k++) begin
      int idx;
      @(posedge clk);
      #1;
      if (k == 2000) resetn = 1'b1;
      if (k == 2002) resetn = 1'b0;
      if ($urandom_range(0, 399) == 0) arm = ~arm;
      if ($urandom_range(0, 29) == 0) begin
        idx = int'($urandom_range(0, 3));
        mot_set[idx] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 110));
      end
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/motor_pwm_gen.md
# motor_pwm_gen

Motor PWM generator that sits directly downstream of the drone control top. It consumes the four 16-bit motor set-points (left, right, forward, rear) and drives four ESC pulse outputs. Every output shares a common fixed PWM period. The block adds an arming sequence, clamps each pulse to safe limits and limits how fast each pulse width may change per period. Set-points are latched once per period, so ESCs never see a partially updated pulse.

## Interface
- PERIOD_CYCLES, 20000: PWM period in clk cycles; legal range 2..65535.
- MIN_PULSE, 1000: minimum high time in cycles, also the idle/arming pulse.
- MAX_PULSE, 2000: maximum high time in cycles; requires MIN_PULSE ≤ MAX_PULSE < PERIOD_CYCLES.
- SLEW_STEP, 20: maximum pulse-width change per period, in cycles; must be ≥ 1.
- ARM_PERIODS, 50: number of MIN_PULSE periods in the arming phase before tracking begins; must be ≥ 1.
- clk, input, 1: single clock for the whole block.
- resetn, input, 1: synchronous, active-high reset; asserted when 1.
- arm, input, 1: level request to enable the motors.
- mot_set, input, [15:0] [3:0]: unsigned set-points in cycles; index 0 = left, 1 = right, 2 = forward, 3 = rear.
- pwm_out, output, [3:0]: ESC pulses, registered.
- armed, output, 1: high only in the ARMED state.
- period_start, output, 1: one-cycle strobe when the period counter equals 0.

## Operation
- Period counter cnt is 16 bits and counts 0..PERIOD_CYCLES-1, then wraps to 0. It runs freely in every state.
- Target per channel: tgt[i] = clamp(mot_set[i], MIN_PULSE, MAX_PULSE). It is sampled only on the cycle where cnt = PERIOD_CYCLES-1.
- Duty update: duty[i] updates on the same cycle as the sample and takes effect from the next cnt = 0.
  - If |tgt − duty| ≤ SLEW_STEP, then duty = tgt.
  - Otherwise duty moves by ±SLEW_STEP toward tgt.
  - Compute the difference with 17-bit signed arithmetic so it never wraps.
- Output: pwm_out[i] is registered from (cnt < duty[i]) when the state is ARMING or ARMED. It is forced to 0 in DISARMED.
- State machine:
  - DISARMED:
    - duty = MIN_PULSE and the arming-period counter = 0.
    - When arm = 1 at a period boundary (cnt = PERIOD_CYCLES-1), go to ARMING.
  - ARMING:
    - duty is held at MIN_PULSE and set-points are ignored.
    - The arming-period counter increments at each boundary.
    - After ARM_PERIODS complete periods, go to ARMED at a boundary.
  - ARMED:
    - Slew tracking is active.
    - Slewing starts from MIN_PULSE.
- Disarm: arm = 0 in ARMING or ARMED moves to DISARMED on the next clk, regardless of cnt. pwm_out is 0 from the following cycle. This is the safety path and does not wait for a period boundary.
- Simultaneous events: if arm falls on a boundary cycle, disarm wins and the duty update is discarded.
- Re-arming always restarts the full ARM_PERIODS sequence.
- mot_set changes mid-period are ignored until the next boundary sample.

## Timing
- Reset values: cnt = 0, state = DISARMED, duty[i] = MIN_PULSE, arming-period counter = 0, pwm_out = 4'b0000, armed = 0, period_start = 0.
- Reset mid-operation: outputs are at reset values on the cycle after resetn is sampled high. There is no partial pulse after reset.
- period_start is registered and high during the cycle in which cnt = 0.
- Set-point latency: a mot_set value present at cnt = PERIOD_CYCLES-1 appears in the pulse starting at the next cnt = 0. That is 1 cycle at minimum and 1 period at maximum.
- Pulse timing: pwm_out is high for exactly duty[i] cycles per period, starting one cycle after cnt = 0 because the output is registered.
- armed rises on the cycle ARMED is entered and falls on the cycle after arm is sampled low.
- Full slew from MIN_PULSE to MAX_PULSE takes ceil((MAX_PULSE − MIN_PULSE)/SLEW_STEP) periods.

## Configuration
- Macro: MOTOR_PWM_SLEW_EN.
  - Defined: slew limiting is active as described in Operation.
  - Undefined: the slew logic is compiled out. duty = tgt at each boundary in ARMED, and the SLEW_STEP parameter is ignored.
- Arming, clamping and disarm behaviour are identical in both builds.

## Structure
- Shared package drone_pkg holds:
  - NUM_MOTORS = 4.
  - Motor index constants MOT_L = 0, MOT_R = 1, MOT_F = 2, MOT_RV = 3.
  - The typedef rpm_t for 16-bit set-points.
  - The enum pwm_state_t {DISARMED, ARMING, ARMED}.
- Sub-module pwm_channel, instantiated once per motor:
  - Contains the clamp, slew/duty register and output compare.
  - Inputs: cnt, the boundary strobe, state and mot_set[i].
- The top level owns cnt, the FSM, the arming-period counter, period_start and armed.

## Test plan
Bench parameters: PERIOD_CYCLES = 100, MIN_PULSE = 10, MAX_PULSE = 80, SLEW_STEP = 5, ARM_PERIODS = 2.
- Reset and arm = 0 for 300 cycles → pwm_out = 0 throughout, armed = 0, period_start pulses every 100 cycles.
- arm = 1 with mot_set[0] = 40 → two periods of 10-cycle pulses, then armed = 1. The next pulses are 15, 20, 25, 30, 35 and 40 cycles, then 40 steady.
- Clamping in ARMED: mot_set[1] = 5 → 10-cycle pulse. mot_set[2] = 65535 → slews to and holds 80 cycles.
- mot_set[3] toggles 30 → 70 → 30 within a single period → only the value present at cnt = 99 is used.
- arm drops mid-pulse at cnt = 20 → pwm_out is 0 by cnt = 22 and armed = 0. Re-arming repeats the two 10-cycle periods.
- Build without MOTOR_PWM_SLEW_EN, armed, mot_set[0] steps 10 → 70 → the next period's pulse is exactly 70 cycles.
